fft_bin_ram_writer: RTL

- Avalon-MM write master that drives the single-port 1024x32 on-chip display RAM slave (address/byteenable/chipselect/write/writedata/clken).
- Accepts a valid/ready stream of 16-bit FFT magnitude bins and packs two bins per 32-bit word.
- Writes completed frames into alternating ping-pong halves of the RAM and reports which half the VGA renderer reads.

---
 rtl/fft_bin_ram_writer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fft_bin_ram_writer.sv
// ============================================================================
// fft_bin_ram_writer: packs 16-bit FFT bins two per word and writes whole
// frames into ping-pong halves of a 1024x32 Avalon-MM display RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_bin_ram_writer #(
  parameter int ADDR_W = 10,
  parameter int BIN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIN_W-1:0]     bin_data,
  input  logic                 bin_valid,
  input  logic                 bin_last,
  output logic                 bin_ready,
  output logic [ADDR_W-1:0]    avm_address,
  output logic [3:0]           avm_byteenable,
  output logic                 avm_chipselect,
  output logic                 avm_write,
  output logic [2*BIN_W-1:0]   avm_writedata,
  output logic                 avm_clken,
  input  logic                 avm_waitrequest,
  output logic                 frame_done,
  output logic                 display_buf,
  output logic                 overflow
);

  localparam logic [1:0] S_LO   = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
  logic [2*BIN_W-1:0] data_q, data_d;
  logic [3:0]         be_q, be_d;
  logic               last_q, last_d;
  logic               display_buf_q, display_buf_d;
  logic               overflow_q, overflow_d;
  logic               clken_q, clken_d;

  logic wr_buf;
  logic half_full;
  logic accept;

  assign wr_buf    = ~display_buf_q;
  // The MSB of the counter only sets once a whole half has been written.
  assign half_full = word_cnt_q[ADDR_W-1];
  assign accept    = bin_valid & bin_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LO;
      word_cnt_q    <= '0;
      data_q        <= '0;
      be_q          <= 4'b0000;
      last_q        <= 1'b0;
      display_buf_q <= 1'b1;
      overflow_q    <= 1'b0;
      clken_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      data_q        <= data_d;
      be_q          <= be_d;
      last_q        <= last_d;
      display_buf_q <= display_buf_d;
      overflow_q    <= overflow_d;
      clken_q       <= clken_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    data_d        = data_q;
    be_d          = be_q;
    last_d        = last_q;
    display_buf_d = display_buf_q;
    overflow_d    = overflow_q;
    clken_d       = 1'b1;
    case (state_q)
      S_LO: begin
        if (accept) begin
          if (half_full) begin
            // Past capacity: swallow bins until the frame ends, never write.
            overflow_d = 1'b1;
            if (bin_last) state_d = S_DONE;
          end else begin
            data_d  = {{BIN_W{1'b0}}, bin_data};
            be_d    = 4'b0011;
            last_d  = bin_last;
            state_d = bin_last ? S_WR : S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          data_d[2*BIN_W-1:BIN_W] = bin_data;
          be_d    = 4'b1111;
          last_d  = bin_last;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          word_cnt_d = word_cnt_q + ADDR_W'(1);
          state_d    = last_q ? S_DONE : S_LO;
        end
      end
      S_DONE: begin
        display_buf_d = wr_buf;
        word_cnt_d    = '0;
        state_d       = S_LO;
      end
      default: state_d = S_LO;
    endcase
  end

  always_comb begin
    bin_ready      = clken_q & ((state_q == S_LO) | (state_q == S_HI));
    avm_write      = (state_q == S_WR);
    avm_chipselect = (state_q == S_WR);
    avm_address    = {wr_buf, word_cnt_q[ADDR_W-2:0]};
    avm_byteenable = be_q;
    avm_writedata  = data_q;
    avm_clken      = clken_q;
    frame_done     = (state_q == S_DONE);
    display_buf    = display_buf_q;
    overflow       = overflow_q;
  end

endmodule

`default_nettype wire
